serial_mult_scheduler: RTL and testbench

Sequencer and two-requester arbiter for the shared 4-bit shift-add `SerialMultiplier` datapath. It accepts multiply requests from two clients and selects one round-robin. It drives the multiplier's operand, `load` and `ctrl` inputs through one load cycle and WIDTH shift cycles, then captures the 2·WIDTH-bit product and returns it to the granted client with a one-cycle done pulse.

---
 rtl/serial_mult_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 26 ++
 rtl/serial_mult_scheduler.sv | 107 ++++++++++
 tb/tb_serial_mult_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_mult_pkg.sv
// rtl/serial_mult_pkg.sv - shared types and sizing for the serial multiplier scheduler
package serial_mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_CAPT  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    // Counter width for an arbitrary operand width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin winner select with registered last-served pointer
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic win,
    output logic valid
);

    logic last;

    assign valid = req0 | req1;
    // Client 1 wins when alone, or on a tie when client 0 was served last.
    assign win   = req1 & (~req0 | ~last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= win;
        end
    end

endmodule

// File: rtl/serial_mult_scheduler.sv
// rtl/serial_mult_scheduler.sv - sequencer and arbiter for the shared shift-add multiplier
module serial_mult_scheduler
    import serial_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               done0,
    output logic               done1,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_load,
    output logic               mul_ctrl,
    input  logic [2*WIDTH-1:0] mul_pq
);

    localparam int CW = cnt_width(WIDTH);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            winner;
    logic            win;
    logic            win_valid;
    logic            accept;

    assign accept = (state == S_IDLE) && win_valid;
    assign busy   = (state != S_IDLE);

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .req1   (req1),
        .accept (accept),
        .win    (win),
        .valid  (win_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            winner   <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            result   <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_load <= 1'b0;
            mul_ctrl <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mul_a    <= win ? a1 : a0;
                        mul_b    <= win ? b1 : b0;
                        gnt0     <= ~win;
                        gnt1     <= win;
                        winner   <= win;
                        mul_load <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    mul_load <= 1'b0;
                    mul_ctrl <= 1'b1;
                    cnt      <= CW'(WIDTH - 1);
                    state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    // Last shift edge: the multiplier has seen WIDTH shift cycles.
                    if (cnt == '0) begin
                        mul_ctrl <= 1'b0;
                        state    <= S_CAPT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_CAPT: begin
                    result <= mul_pq;
                    done0  <= ~winner;
                    done1  <= winner;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mult_scheduler.sv
// tb/tb_serial_mult_scheduler.sv - scoreboard bench for serial_mult_scheduler with a shift-add multiplier model
module tb_serial_mult_scheduler;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req0, req1;
    logic [W-1:0]   a0, b0, a1, b1;
    logic           gnt0, gnt1, done0, done1, busy;
    logic [2*W-1:0] result;
    logic [W-1:0]   mul_a, mul_b;
    logic           mul_load, mul_ctrl;
    logic [2*W-1:0] mul_pq;

    serial_mult_scheduler #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .result   (result),
        .busy     (busy),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_load (mul_load),
        .mul_ctrl (mul_ctrl),
        .mul_pq   (mul_pq)
    );

    always #5 clk = ~clk;

    // Shift-add multiplier: load operands, then one add-and-shift per ctrl cycle.
    logic [W-1:0]   m_cand, m_acc, m_q;
    logic [W:0]     m_sum;
    logic [2*W:0]   m_nxt;
    assign m_sum  = {1'b0, m_acc} + (m_q[0] ? {1'b0, m_cand} : '0);
    assign m_nxt  = {m_sum, m_q} >> 1;
    assign mul_pq = {m_acc, m_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cand <= '0;
            m_acc  <= '0;
            m_q    <= '0;
        end else if (mul_load) begin
            m_cand <= mul_a;
            m_q    <= mul_b;
            m_acc  <= '0;
        end else if (mul_ctrl) begin
            {m_acc, m_q} <= m_nxt[2*W-1:0];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    logic [8:0] res_q[$];   // {client, product}
    bit         gnt_q[$];
    logic [8:0] exp_res;
    int         gnt_cyc = 0;
    int         last_done_cyc = -100;
    int         n_load = 0;
    int         n_ctrl = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("load_ctrl_overlap", 32'(mul_load && mul_ctrl), 0);
            if (gnt0 || gnt1) begin
                chk("gnt_both", 32'(gnt0 && gnt1), 0);
                if (gnt_q.size() == 0) chk("unexpected_gnt", 1, 0);
                else chk("gnt_client", 32'(gnt1), 32'(gnt_q.pop_front()));
                gnt_cyc = cyc;
                n_load  = 0;
                n_ctrl  = 0;
            end
            n_load += int'(mul_load);
            n_ctrl += int'(mul_ctrl);
            if (done0 || done1) begin
                chk("done_both", 32'(done0 && done1), 0);
                chk("done_latency", 32'(cyc - gnt_cyc), 6);
                chk("load_cycles", 32'(n_load), 1);
                chk("ctrl_cycles", 32'(n_ctrl), 4);
                last_done_cyc = cyc;
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_res = res_q.pop_front();
                    chk("done_client", 32'(done1), 32'(exp_res[8]));
                    chk("result", 32'(result), 32'(exp_res[7:0]));
                end
            end
        end
    end

    task automatic req_client(input bit c, input logic [W-1:0] a, input logic [W-1:0] b);
        bit seen = 0;
        @(negedge clk);
        if (c) begin a1 = a; b1 = b; req1 = 1'b1; end
        else   begin a0 = a; b0 = b; req0 = 1'b1; end
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            seen = c ? gnt1 : gnt0;
        end
        if (!seen) chk("gnt_timeout", 1, 0);
        if (c) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 80 && res_q.size() != 0; n++) @(negedge clk);
        chk("drain_timeout", 32'(res_q.size()), 0);
        @(negedge clk);
    endtask

    task automatic tie_round();
        bit g0 = 0, g1 = 0;
        gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
        res_q.push_back({1'b0, 8'd10}); res_q.push_back({1'b1, 8'd63});
        @(negedge clk);
        a0 = 4'd2; b0 = 4'd5; a1 = 4'd7; b1 = 4'd9;
        req0 = 1'b1; req1 = 1'b1;
        for (int n = 0; n < 60 && !(g0 && g1); n++) begin
            @(negedge clk);
            if (gnt0) begin g0 = 1; req0 = 1'b0; end
            if (gnt1) begin
                g1 = 1; req1 = 1'b0;
                chk("tie_gnt1_after_done0", 32'(cyc), 32'(last_done_cyc + 1));
            end
        end
        if (!(g0 && g1)) chk("tie_timeout", 1, 0);
        drain();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_result"}, 32'(result), 0);
        chk({tag, "_mul_ab"}, 32'({mul_a, mul_b}), 0);
        chk({tag, "_ctl"}, 32'({busy, mul_load, mul_ctrl, gnt0, gnt1, done0, done1}), 0);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        // single request 3x12
        gnt_q.push_back(1'b0); res_q.push_back({1'b0, 8'h24});
        req_client(0, 4'd3, 4'd12);
        chk("load_at_gnt", 32'({mul_load, mul_ctrl, busy}), 32'b101);
        drain();

        // maximum operands from client 1
        gnt_q.push_back(1'b1); res_q.push_back({1'b1, 8'hE1});
        req_client(1, 4'd15, 4'd15);
        drain();

        // two tie rounds from a fresh pointer
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tie_round();
        tie_round();

        // client 1 requests during client 0 SHIFT
        gnt_q.push_back(1'b0); res_q.push_back({1'b0, 8'd42});
        gnt_q.push_back(1'b1); res_q.push_back({1'b1, 8'd55});
        req_client(0, 4'd6, 4'd7);
        repeat (2) @(negedge clk);
        a1 = 4'd5; b1 = 4'd11; req1 = 1'b1;
        seen = 0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            seen = gnt1;
        end
        req1 = 1'b0;
        chk("busy_gnt1_after_done0", 32'(cyc), 32'(last_done_cyc + 1));
        drain();

        // reset during second SHIFT cycle aborts without done
        gnt_q.push_back(1'b0);
        req_client(0, 4'd9, 4'd9);
        repeat (2) @(negedge clk);
        chk("pre_abort_shift", 32'({busy, mul_ctrl}), 32'b11);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        gnt_q.push_back(1'b0); res_q.push_back({1'b0, 8'd16});
        req_client(0, 4'd4, 4'd4);
        drain();

        // zero operand keeps full latency
        gnt_q.push_back(1'b0); res_q.push_back({1'b0, 8'd0});
        req_client(0, 4'd0, 4'd9);
        drain();

        chk("gnt_queue_empty", 32'(gnt_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
